pixel_ram_arbiter: RTL and testbench

Shares the single pixel-RAM command FIFO between two requesters: the display refresh loader (reads only) and the host frame port (reads and writes). It issues one command per cycle, tracks outstanding reads in an in-order tag queue, and routes each returned read byte back to the requester that issued it. It sits between the LED matrix controller's pixel loader and the external-RAM command/response FIFOs.

---
 rtl/pixel_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_pixel_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_ram_arbiter.sv
// rtl/pixel_ram_arbiter.sv - display/host arbiter for the pixel-RAM command FIFO with in-order read tag routing
// Optional macro STARVATION_GUARD_EN: forces a host grant after MAX_WAIT denied cycles.
module pixel_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int TAG_DEPTH     = 16,
  parameter int MAX_WAIT      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_req,
  input  logic [ADDRESS_WIDTH-1:0]     disp_address,
  output logic                         disp_gnt,
  output logic [7:0]                   disp_data,
  output logic                         disp_data_ready,
  input  logic                         host_req,
  input  logic                         host_wr,
  input  logic [ADDRESS_WIDTH-1:0]     host_address,
  input  logic [7:0]                   host_data_in,
  output logic                         host_gnt,
  output logic [7:0]                   host_data,
  output logic                         host_data_ready,
  output logic [ADDRESS_WIDTH-1:0]     address_fifo,
  output logic                         wr_fifo,
  output logic [7:0]                   data_out_fifo,
  output logic                         data_out_ready_fifo,
  input  logic                         fifo_full,
  input  logic [7:0]                   data_in_fifo,
  input  logic                         data_in_ready_fifo,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         rsp_error
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 room;
  logic                 disp_elig;
  logic                 host_elig;
  logic                 host_pri;
  logic                 push;
  logic                 pop;

  // Eligibility uses the pre-edge count, so a same-cycle pop never frees a slot early.
  assign room      = outstanding < TAG_FULL;
  assign disp_elig = disp_req & ~fifo_full & room;
  assign host_elig = host_req & ~fifo_full & (host_wr | room);

`ifdef STARVATION_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign host_pri = (wait_cnt == WAIT_SAT);
`else
  logic [31:0] unused_max_wait;
  assign unused_max_wait = 32'(MAX_WAIT);
  assign host_pri        = 1'b0;
`endif

  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    if (host_pri && host_elig) begin
      host_gnt = 1'b1;
    end else if (disp_elig) begin
      disp_gnt = 1'b1;
    end else begin
      host_gnt = host_elig;
    end
  end

  assign push = disp_gnt | (host_gnt & ~host_wr);
  assign pop  = data_in_ready_fifo & (outstanding != '0);

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= host_gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_fifo        <= '0;
      wr_fifo             <= 1'b0;
      data_out_fifo       <= '0;
      data_out_ready_fifo <= 1'b0;
      disp_data           <= '0;
      disp_data_ready     <= 1'b0;
      host_data           <= '0;
      host_data_ready     <= 1'b0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      outstanding         <= '0;
      rsp_error           <= 1'b0;
    end else begin
      data_out_ready_fifo <= disp_gnt | host_gnt;
      disp_data_ready     <= 1'b0;
      host_data_ready     <= 1'b0;

      if (disp_gnt) begin
        address_fifo  <= disp_address;
        wr_fifo       <= 1'b0;
        data_out_fifo <= '0;
      end else if (host_gnt) begin
        address_fifo  <= host_address;
        wr_fifo       <= host_wr;
        data_out_fifo <= host_data_in;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (tag_mem[rd_ptr]) begin
          host_data       <= data_in_fifo;
          host_data_ready <= 1'b1;
        end else begin
          disp_data       <= data_in_fifo;
          disp_data_ready <= 1'b1;
        end
      end else if (data_in_ready_fifo) begin
        rsp_error <= 1'b1;
      end

      if (push && !pop) begin
        outstanding <= outstanding + CW'(1);
      end else if (pop && !push) begin
        outstanding <= outstanding - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// tb/tb_pixel_ram_arbiter.sv - directed and randomized check of pixel_ram_arbiter against a queue-based model
module tb_pixel_ram_arbiter;

  localparam int AW = 25;
  localparam int TD = 16;
  localparam int MW = 8;
`ifdef STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_address = '0;
  logic          disp_gnt;
  logic [7:0]    disp_data;
  logic          disp_data_ready;
  logic          host_req = 1'b0;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic [7:0]    host_data_in = '0;
  logic          host_gnt;
  logic [7:0]    host_data;
  logic          host_data_ready;
  logic [AW-1:0] address_fifo;
  logic          wr_fifo;
  logic [7:0]    data_out_fifo;
  logic          data_out_ready_fifo;
  logic          fifo_full = 1'b0;
  logic [7:0]    data_in_fifo = '0;
  logic          data_in_ready_fifo = 1'b0;
  logic [4:0]    outstanding;
  logic          rsp_error;

  pixel_ram_arbiter #(.ADDRESS_WIDTH(AW), .TAG_DEPTH(TD), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_address(disp_address), .disp_gnt(disp_gnt),
    .disp_data(disp_data), .disp_data_ready(disp_data_ready),
    .host_req(host_req), .host_wr(host_wr), .host_address(host_address),
    .host_data_in(host_data_in), .host_gnt(host_gnt), .host_data(host_data),
    .host_data_ready(host_data_ready),
    .address_fifo(address_fifo), .wr_fifo(wr_fifo), .data_out_fifo(data_out_fifo),
    .data_out_ready_fifo(data_out_ready_fifo), .fifo_full(fifo_full),
    .data_in_fifo(data_in_fifo), .data_in_ready_fifo(data_in_ready_fifo),
    .outstanding(outstanding), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: tags in issue order, 0 = display, 1 = host.
  int            tq[$];
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [7:0]    m_dout;
  logic          m_cmd_vld;
  logic [7:0]    m_disp_data, m_host_data;
  logic          m_disp_rdy, m_host_rdy;
  logic          m_err;
  int            m_wait;
  bit            last_host_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    m_addr = '0; m_wr = 1'b0; m_dout = '0; m_cmd_vld = 1'b0;
    m_disp_data = '0; m_host_data = '0; m_disp_rdy = 1'b0; m_host_rdy = 1'b0;
    m_err = 1'b0; m_wait = 0;
  endtask

  task automatic check_regs(input string p);
    check({p, "_addr"}, 32'(address_fifo), 32'(m_addr));
    check({p, "_wr"}, 32'(wr_fifo), 32'(m_wr));
    check({p, "_dout"}, 32'(data_out_fifo), 32'(m_dout));
    check({p, "_cmdv"}, 32'(data_out_ready_fifo), 32'(m_cmd_vld));
    check({p, "_ddata"}, 32'(disp_data), 32'(m_disp_data));
    check({p, "_drdy"}, 32'(disp_data_ready), 32'(m_disp_rdy));
    check({p, "_hdata"}, 32'(host_data), 32'(m_host_data));
    check({p, "_hrdy"}, 32'(host_data_ready), 32'(m_host_rdy));
    check({p, "_outst"}, 32'(outstanding), 32'(tq.size()));
    check({p, "_rsperr"}, 32'(rsp_error), 32'(m_err));
  endtask

  // One clock: grants are judged mid-cycle, registered outputs just after the edge.
  task automatic step();
    int sz;
    bit de, he, gd, gh;
    sz = tq.size();
    de = disp_req && !fifo_full && (sz < TD);
    he = host_req && !fifo_full && (host_wr || (sz < TD));
    if (GUARD && (m_wait == MW) && he) begin
      gd = 1'b0; gh = 1'b1;
    end else begin
      gd = de; gh = he && !de;
    end
    #1;
    check("disp_gnt", 32'(disp_gnt), 32'(gd));
    check("host_gnt", 32'(host_gnt), 32'(gh));
    last_host_gnt = host_gnt;
    @(posedge clk);
    m_cmd_vld = gd || gh;
    if (gd) begin
      m_addr = disp_address; m_wr = 1'b0; m_dout = '0;
    end else if (gh) begin
      m_addr = host_address; m_wr = host_wr; m_dout = host_data_in;
    end
    m_disp_rdy = 1'b0;
    m_host_rdy = 1'b0;
    if (data_in_ready_fifo) begin
      if (sz == 0) begin
        m_err = 1'b1;
      end else if (tq.pop_front() == 1) begin
        m_host_data = data_in_fifo; m_host_rdy = 1'b1;
      end else begin
        m_disp_data = data_in_fifo; m_disp_rdy = 1'b1;
      end
    end
    if (gd) tq.push_back(0);
    if (gh && !host_wr) tq.push_back(1);
    if (!host_req || gh) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    #1;
    check_regs("cyc");
  endtask

  task automatic drive(input bit dr, input logic [AW-1:0] da, input bit hr, input bit hw,
                       input logic [AW-1:0] ha, input logic [7:0] hd, input bit rv,
                       input logic [7:0] rd, input bit ff);
    disp_req = dr; disp_address = da;
    host_req = hr; host_wr = hw; host_address = ha; host_data_in = hd;
    data_in_ready_fifo = rv; data_in_fifo = rd; fifo_full = ff;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_regs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int hg;

  initial begin
    model_reset();
    #1;
    do_reset();

    // Single host write reaches the command registers for exactly one cycle.
    drive(0, 0, 1, 1, 'h10, 'hA5, 0, 0, 0);
    check("t1_addr", 32'(address_fifo), 32'h10);
    check("t1_wr", 32'(wr_fifo), 1);
    check("t1_dout", 32'(data_out_fifo), 32'hA5);
    check("t1_vld", 32'(data_out_ready_fifo), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_vld_off", 32'(data_out_ready_fifo), 0);

    // Two display reads and one host read, responses routed in order.
    drive(1, 'h0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 'h1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 'h20, 0, 0, 0, 0);
    check("t2_outst3", 32'(outstanding), 3);
    drive(0, 0, 0, 0, 0, 0, 1, 'h11, 0);
    check("t2_d0", 32'({disp_data_ready, disp_data}), 32'h111);
    drive(0, 0, 0, 0, 0, 0, 1, 'h22, 0);
    check("t2_d1", 32'({disp_data_ready, disp_data}), 32'h122);
    drive(0, 0, 0, 0, 0, 0, 1, 'h33, 0);
    check("t2_h0", 32'({host_data_ready, host_data}), 32'h133);
    check("t2_outst0", 32'(outstanding), 0);

    // Fill the tag queue; reads block, host writes still pass.
    for (int i = 0; i < TD; i++) drive(1, AW'(i), 0, 0, 0, 0, 0, 0, 0);
    check("t3_full", 32'(outstanding), 16);
    drive(1, 'h40, 1, 0, 'h50, 0, 0, 0, 0);
    check("t3_blocked", 32'(data_out_ready_fifo), 0);
    drive(1, 'h40, 1, 1, 'h30, 'h5A, 0, 0, 0);
    check("t3_hwr", 32'({wr_fifo, data_out_fifo}), 32'h15A);
    drive(1, 'h40, 0, 0, 0, 0, 1, 'h77, 0);
    check("t3_pop", 32'(outstanding), 15);
    drive(1, 'h40, 0, 0, 0, 0, 0, 0, 0);
    check("t3_regrant", 32'(address_fifo), 32'h40);
    for (int i = 0; i < TD; i++) drive(0, 0, 0, 0, 0, 0, 1, 8'(i + 1), 0);
    check("t3_drained", 32'(outstanding), 0);

    // Response with empty queue is dropped and the error sticks.
    drive(0, 0, 0, 0, 0, 0, 1, 'hEE, 0);
    check("t4_err", 32'({rsp_error, disp_data_ready, host_data_ready}), 32'b100);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_sticky", 32'(rsp_error), 1);
    do_reset();

    // Both requesters held: host grants appear only with the starvation guard.
    hg = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, AW'(i), 1, 1, 'h99, 8'(i), tq.size() > 0, 8'(i), 0);
      if (last_host_gnt) hg++;
    end
    check("t5_host_grants", 32'(hg), GUARD ? 1 : 0);
    while (tq.size() > 0) drive(0, 0, 0, 0, 0, 0, 1, 'h01, 0);

    // Full command FIFO stalls everything; reset clears outstanding reads.
    drive(1, 'h3, 1, 0, 'h4, 0, 0, 0, 1);
    check("t6_stall", 32'(data_out_ready_fifo), 0);
    for (int i = 0; i < 3; i++) drive(1, AW'(i), 0, 0, 0, 0, 0, 0, 0);
    check("t6_outst3", 32'(outstanding), 3);
    do_reset();
    check("t6_rst_outst", 32'(outstanding), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 'h55, 0);
    check("t6_late_err", 32'(rsp_error), 1);
    do_reset();

    // Randomized traffic with varying response pressure and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      int rp;
      rp = ((i / 250) % 2 == 1) ? 4 : 1;
      drive($urandom_range(0, 1), AW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            AW'($urandom), 8'($urandom), (tq.size() > 0) && ($urandom_range(0, 4) >= rp),
            8'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
